// File: rtl/mem_rd_arbiter_pkg.sv
// Shared types and defaults for the memory read arbiter slice.
package mem_rd_arbiter_pkg;

   // Source tag carried with every accepted read so its response can be routed back
   typedef enum logic {
      SRC_DESC = 1'b0,
      SRC_DMA  = 1'b1
   } rd_src_e;

   // Default number of reads that may be accepted but not yet returned
   localparam int unsigned RD_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/mem_rd_arbiter_tag_fifo.sv
// In-order FIFO of read source tags; one entry per read in flight to memory.
module rd_tag_fifo
   import mem_rd_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = RD_MAX_OUTSTANDING
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  rd_src_e                    push_tag,
   input  logic                       pop,
   output rd_src_e                    pop_tag,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   rd_src_e            tag_mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count_q;
   logic               do_push;
   logic               do_pop;

   // Status flags and guarded push/pop strobes
   always_comb begin
      full    = (count_q == CNT_W'(DEPTH));
      empty   = (count_q == '0);
      do_push = push && !full;
      do_pop  = pop && !empty;
      count   = count_q;
      pop_tag = tag_mem[rd_ptr];
   end

   // Tag storage: written at the write pointer on every accepted push
   always_ff @(posedge clk) begin
      if (do_push) begin
         tag_mem[wr_ptr] <= push_tag;
      end
   end

   // Pointers wrap naturally modulo the power-of-two depth; count tracks occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing the single memory read port between descriptor
// fetches and DMA data reads; responses return in order and are routed by tag.
module mem_rd_arbiter
   import mem_rd_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W          = 32,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned MAX_OUTSTANDING = RD_MAX_OUTSTANDING
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              desc_req_valid,
   input  logic [ADDR_W-1:0] desc_req_addr,
   output logic              desc_req_ready,
   output logic              desc_rsp_valid,
   output logic [DATA_W-1:0] desc_rsp_data,
   input  logic              dma_req_valid,
   input  logic [ADDR_W-1:0] dma_req_addr,
   output logic              dma_req_ready,
   output logic              dma_rsp_valid,
   output logic [DATA_W-1:0] dma_rsp_data,
   output logic              mem_read_en,
   output logic [ADDR_W-1:0] mem_read_addr,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic              mem_read_valid,
   output logic              busy,
   output logic              err_unexpected
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   rd_src_e             last_grant;
   rd_src_e             acc_tag;
   rd_src_e             head_tag;
   logic                desc_acc;
   logic                dma_acc;
   logic                acc;
   logic [ADDR_W-1:0]   acc_addr;
   logic                tag_pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;

   // Readys and acceptance: the source not granted last wins a tie
   always_comb begin
      desc_req_ready = !fifo_full && (!dma_req_valid  || last_grant == SRC_DMA);
      dma_req_ready  = !fifo_full && (!desc_req_valid || last_grant == SRC_DESC);
      desc_acc       = desc_req_valid && desc_req_ready;
      dma_acc        = dma_req_valid && dma_req_ready;
      acc            = desc_acc || dma_acc;
      acc_tag        = desc_acc ? SRC_DESC : SRC_DMA;
      acc_addr       = desc_acc ? desc_req_addr : dma_req_addr;
      tag_pop        = mem_read_valid && !fifo_empty;
      busy           = (fifo_count != '0);
   end

   rd_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (acc),
      .push_tag (acc_tag),
      .pop      (tag_pop),
      .pop_tag  (head_tag),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Round-robin pointer moves only when a request is actually accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= SRC_DMA;
      end else if (acc) begin
         last_grant <= acc_tag;
      end
   end

   // Issue register: one-cycle read strobe, address held between reads
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_read_en   <= 1'b0;
         mem_read_addr <= '0;
      end else begin
         mem_read_en <= acc;
         if (acc) begin
            mem_read_addr <= acc_addr;
         end
      end
   end

   // Response register: route returned data to the source at the FIFO head
   always_ff @(posedge clk) begin
      if (rst) begin
         desc_rsp_valid <= 1'b0;
         desc_rsp_data  <= '0;
         dma_rsp_valid  <= 1'b0;
         dma_rsp_data   <= '0;
      end else begin
         desc_rsp_valid <= tag_pop && (head_tag == SRC_DESC);
         dma_rsp_valid  <= tag_pop && (head_tag == SRC_DMA);
         if (tag_pop && head_tag == SRC_DESC) begin
            desc_rsp_data <= mem_read_data;
         end
         if (tag_pop && head_tag == SRC_DMA) begin
            dma_rsp_data <= mem_read_data;
         end
      end
   end

   // Sticky flag for a memory return with nothing outstanding
   always_ff @(posedge clk) begin
      if (rst) begin
         err_unexpected <= 1'b0;
      end else if (mem_read_valid && fifo_empty) begin
         err_unexpected <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter with a small in-order memory responder.
module tb_mem_rd_arbiter;

   localparam int unsigned L = 2;

   logic        clk;
   logic        rst;
   logic        desc_req_valid;
   logic [31:0] desc_req_addr;
   logic        desc_req_ready;
   logic        desc_rsp_valid;
   logic [31:0] desc_rsp_data;
   logic        dma_req_valid;
   logic [31:0] dma_req_addr;
   logic        dma_req_ready;
   logic        dma_rsp_valid;
   logic [31:0] dma_rsp_data;
   logic        mem_read_en;
   logic [31:0] mem_read_addr;
   logic [31:0] mem_read_data;
   logic        mem_read_valid;
   logic        busy;
   logic        err_unexpected;

   int unsigned n_vec;
   int unsigned n_err;

   // memory responder controls
   logic        stall;
   logic        release_one;
   logic        inject;
   logic [31:0] inject_data;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } mreq_t;

   mreq_t       mq[$];
   int unsigned cyc;

   mem_rd_arbiter #(
      .ADDR_W          (32),
      .DATA_W          (32),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .desc_req_valid (desc_req_valid),
      .desc_req_addr  (desc_req_addr),
      .desc_req_ready (desc_req_ready),
      .desc_rsp_valid (desc_rsp_valid),
      .desc_rsp_data  (desc_rsp_data),
      .dma_req_valid  (dma_req_valid),
      .dma_req_addr   (dma_req_addr),
      .dma_req_ready  (dma_req_ready),
      .dma_rsp_valid  (dma_rsp_valid),
      .dma_rsp_data   (dma_rsp_data),
      .mem_read_en    (mem_read_en),
      .mem_read_addr  (mem_read_addr),
      .mem_read_data  (mem_read_data),
      .mem_read_valid (mem_read_valid),
      .busy           (busy),
      .err_unexpected (err_unexpected)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory returns data = addr ^ 32'hDEADBEAF, L cycles after the read strobe, in order.
   initial begin
      cyc            = 0;
      mem_read_valid = 1'b0;
      mem_read_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (mem_read_en === 1'b1) begin
            mq.push_back('{mem_read_addr, cyc + L});
         end
         mem_read_valid = 1'b0;
         if (inject) begin
            mem_read_valid = 1'b1;
            mem_read_data  = inject_data;
         end else if (mq.size() > 0 && mq[0].due <= cyc && (!stall || release_one)) begin
            mem_read_valid = 1'b1;
            mem_read_data  = mq[0].addr ^ 32'hDEADBEAF;
            void'(mq.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset(input int unsigned n);
      desc_req_valid = 1'b0;
      dma_req_valid  = 1'b0;
      rst            = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(2);
      #1;
      n_vec++; if (desc_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_desc_ready got=%b exp=1", desc_req_ready); end
      n_vec++; if (dma_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_dma_ready got=%b exp=1", dma_req_ready); end
      n_vec++; if (mem_read_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_read_en got=%b exp=0", mem_read_en); end
      n_vec++; if (mem_read_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_read_addr got=%h exp=0", mem_read_addr); end
      n_vec++; if (desc_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_desc_rsp_valid got=%b exp=0", desc_rsp_valid); end
      n_vec++; if (dma_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_dma_rsp_valid got=%b exp=0", dma_rsp_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_vec++; if (err_unexpected !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", err_unexpected); end
   endtask

   task automatic test_single_desc();
      do_reset(2);
      desc_req_valid = 1'b1;
      desc_req_addr  = 32'h40;
      #1;
      n_vec++; if (desc_req_ready !== 1'b1) begin n_err++; $display("FAIL single_desc_ready got=%b exp=1", desc_req_ready); end
      n_vec++; if (dma_req_ready !== 1'b0) begin n_err++; $display("FAIL single_dma_ready got=%b exp=0", dma_req_ready); end
      for (int unsigned k = 1; k <= 5; k++) begin
         @(negedge clk);
         desc_req_valid = 1'b0;
         #1;
         n_vec++; if (mem_read_en !== (k == 1)) begin n_err++; $display("FAIL single_en k=%0d got=%b exp=%b", k, mem_read_en, (k == 1)); end
         n_vec++; if (mem_read_addr !== 32'h40) begin n_err++; $display("FAIL single_addr k=%0d got=%h exp=40", k, mem_read_addr); end
         n_vec++; if (busy !== (k <= 3)) begin n_err++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, (k <= 3)); end
         n_vec++; if (desc_rsp_valid !== (k == 4)) begin n_err++; $display("FAIL single_desc_rsp k=%0d got=%b exp=%b", k, desc_rsp_valid, (k == 4)); end
         n_vec++; if (dma_rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_dma_rsp k=%0d got=%b exp=0", k, dma_rsp_valid); end
         if (k >= 4) begin
            n_vec++; if (desc_rsp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_desc_data k=%0d got=%h exp=deadbeef", k, desc_rsp_data); end
         end
      end
   endtask

   task automatic test_round_robin();
      logic        exp_dr, exp_mr, exp_en, exp_drsp, exp_mrsp;
      logic [31:0] exp_addr;
      do_reset(2);
      desc_req_addr = 32'h100;
      dma_req_addr  = 32'h200;
      for (int unsigned k = 0; k <= 8; k++) begin
         if (k > 0) @(negedge clk);
         desc_req_valid = (k < 4);
         dma_req_valid  = (k < 4);
         #1;
         exp_dr   = (k >= 4) || (k % 2 == 0);
         exp_mr   = (k >= 4) || (k % 2 == 1);
         exp_en   = (k >= 1 && k <= 4);
         exp_addr = (k == 0) ? 32'h0 : ((k == 1 || k == 3) ? 32'h100 : 32'h200);
         exp_drsp = (k == 4 || k == 6);
         exp_mrsp = (k == 5 || k == 7);
         n_vec++; if (desc_req_ready !== exp_dr) begin n_err++; $display("FAIL rr_desc_ready k=%0d got=%b exp=%b", k, desc_req_ready, exp_dr); end
         n_vec++; if (dma_req_ready !== exp_mr) begin n_err++; $display("FAIL rr_dma_ready k=%0d got=%b exp=%b", k, dma_req_ready, exp_mr); end
         n_vec++; if (mem_read_en !== exp_en) begin n_err++; $display("FAIL rr_en k=%0d got=%b exp=%b", k, mem_read_en, exp_en); end
         n_vec++; if (mem_read_addr !== exp_addr) begin n_err++; $display("FAIL rr_addr k=%0d got=%h exp=%h", k, mem_read_addr, exp_addr); end
         n_vec++; if (desc_rsp_valid !== exp_drsp) begin n_err++; $display("FAIL rr_desc_rsp k=%0d got=%b exp=%b", k, desc_rsp_valid, exp_drsp); end
         n_vec++; if (dma_rsp_valid !== exp_mrsp) begin n_err++; $display("FAIL rr_dma_rsp k=%0d got=%b exp=%b", k, dma_rsp_valid, exp_mrsp); end
         if (k >= 4) begin
            n_vec++; if (desc_rsp_data !== 32'hDEADBFAF) begin n_err++; $display("FAIL rr_desc_data k=%0d got=%h exp=deadbfaf", k, desc_rsp_data); end
         end
         if (k >= 5) begin
            n_vec++; if (dma_rsp_data !== 32'hDEADBCAF) begin n_err++; $display("FAIL rr_dma_data k=%0d got=%h exp=deadbcaf", k, dma_rsp_data); end
         end
      end
   endtask

   task automatic test_full();
      logic        exp_rdy, exp_en;
      int unsigned dma_cnt;
      int unsigned desc_cnt;
      bit          drained;
      do_reset(2);
      stall         = 1'b1;
      dma_req_addr  = 32'h300;
      dma_req_valid = 1'b1;
      dma_cnt       = 0;
      desc_cnt      = 0;
      for (int unsigned k = 0; k <= 8; k++) begin
         if (k > 0) @(negedge clk);
         release_one = (k == 5);
         #1;
         exp_rdy = (k <= 3) || (k == 7);
         exp_en  = (k >= 1 && k <= 4) || (k == 8);
         n_vec++; if (dma_req_ready !== exp_rdy) begin n_err++; $display("FAIL full_dma_ready k=%0d got=%b exp=%b", k, dma_req_ready, exp_rdy); end
         n_vec++; if (mem_read_en !== exp_en) begin n_err++; $display("FAIL full_en k=%0d got=%b exp=%b", k, mem_read_en, exp_en); end
         n_vec++; if (dma_rsp_valid !== (k == 7)) begin n_err++; $display("FAIL full_dma_rsp k=%0d got=%b exp=%b", k, dma_rsp_valid, (k == 7)); end
         if (dma_rsp_valid === 1'b1) dma_cnt++;
         if (desc_rsp_valid === 1'b1) desc_cnt++;
         if (k == 7) begin
            n_vec++; if (dma_rsp_data !== 32'hDEADBDAF) begin n_err++; $display("FAIL full_dma_data got=%h exp=deadbdaf", dma_rsp_data); end
         end
      end
      dma_req_valid = 1'b0;
      stall         = 1'b0;
      drained       = 1'b0;
      for (int unsigned i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dma_rsp_valid === 1'b1) dma_cnt++;
         if (desc_rsp_valid === 1'b1) desc_cnt++;
         if (busy === 1'b0) begin
            drained = 1'b1;
            break;
         end
      end
      n_vec++; if (drained !== 1'b1) begin n_err++; $display("FAIL full_drain_timeout busy=%b exp=0", busy); end
      n_vec++; if (dma_cnt !== 5) begin n_err++; $display("FAIL full_dma_rsp_count got=%0d exp=5", dma_cnt); end
      n_vec++; if (desc_cnt !== 0) begin n_err++; $display("FAIL full_desc_rsp_count got=%0d exp=0", desc_cnt); end
   endtask

   task automatic test_unexpected();
      do_reset(2);
      inject_data = 32'h12345678;
      inject      = 1'b1;
      for (int unsigned k = 1; k <= 5; k++) begin
         @(negedge clk);
         inject = 1'b0;
         #1;
         n_vec++; if (desc_rsp_valid !== 1'b0) begin n_err++; $display("FAIL unexp_desc_rsp k=%0d got=%b exp=0", k, desc_rsp_valid); end
         n_vec++; if (dma_rsp_valid !== 1'b0) begin n_err++; $display("FAIL unexp_dma_rsp k=%0d got=%b exp=0", k, dma_rsp_valid); end
         n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL unexp_busy k=%0d got=%b exp=0", k, busy); end
         n_vec++; if (err_unexpected !== (k >= 2)) begin n_err++; $display("FAIL unexp_err k=%0d got=%b exp=%b", k, err_unexpected, (k >= 2)); end
      end
      do_reset(2);
      #1;
      n_vec++; if (err_unexpected !== 1'b0) begin n_err++; $display("FAIL unexp_err_cleared got=%b exp=0", err_unexpected); end
   endtask

   task automatic test_reset_mid_flight();
      do_reset(2);
      desc_req_valid = 1'b1;
      for (int unsigned k = 0; k <= 12; k++) begin
         if (k > 0) @(negedge clk);
         case (k)
            0: desc_req_addr = 32'h500;
            1: desc_req_addr = 32'h504;
            2: desc_req_addr = 32'h508;
            3: begin desc_req_valid = 1'b0; rst = 1'b1; end
            6: rst = 1'b0;
            8: begin desc_req_valid = 1'b1; desc_req_addr = 32'h40; end
            9: desc_req_valid = 1'b0;
            default: ;
         endcase
         #1;
         if (k == 3) begin
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
         end
         if (k >= 4 && k <= 8) begin
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy k=%0d got=%b exp=0", k, busy); end
         end
         if (k >= 4) begin
            n_vec++; if (desc_rsp_valid !== (k == 12)) begin n_err++; $display("FAIL midrst_desc_rsp k=%0d got=%b exp=%b", k, desc_rsp_valid, (k == 12)); end
            n_vec++; if (dma_rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_dma_rsp k=%0d got=%b exp=0", k, dma_rsp_valid); end
            n_vec++; if (err_unexpected !== 1'b0) begin n_err++; $display("FAIL midrst_err k=%0d got=%b exp=0", k, err_unexpected); end
         end
         if (k == 9) begin
            n_vec++; if (mem_read_addr !== 32'h40) begin n_err++; $display("FAIL midrst_new_addr got=%h exp=40", mem_read_addr); end
         end
         if (k == 12) begin
            n_vec++; if (desc_rsp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL midrst_new_data got=%h exp=deadbeef", desc_rsp_data); end
         end
      end
   endtask

   initial begin
      n_vec          = 0;
      n_err          = 0;
      rst            = 1'b1;
      desc_req_valid = 1'b0;
      desc_req_addr  = '0;
      dma_req_valid  = 1'b0;
      dma_req_addr   = '0;
      stall          = 1'b0;
      release_one    = 1'b0;
      inject         = 1'b0;
      inject_data    = '0;
      @(negedge clk);
      test_reset();
      test_single_desc();
      test_round_robin();
      test_full();
      test_unexpected();
      test_reset_mid_flight();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
